sprite_anim_seq: RTL and testbench
==================================

// Module: sprite_anim_seq
// PURPOSE
//  Multi-channel sprite-frame sequencer; parametrised successor of the fixed 4-frame coin animator.
//  Each channel steps a sprite id through FRAMES consecutive ids (BASE_ID..BASE_ID+FRAMES-1).
//  Stepping is paced by the shared clk_flash_anim toggle and a per-channel prescaler.
//  Modes: loop, ping-pong, one-shot (with done pulse), hold. Feeds sprite ids to the VGA renderer.
// PARAMETERS
//  NUM_CH   4   number of independent animation channels
//  ID_W     6   sprite id width
//  FRAMES   4   frames per animation (>=1)
//  BASE_ID  4   id of frame 0
//  NULL_ID  63  id driven while channel idle (transparent sprite)
//  DIV_W    4   prescaler width; channel advances every (div+1) flash ticks
// PORTS
//  clk             in   1            system clock
//  rstn            in   1            synchronous reset, ACTIVE-HIGH (1 = reset), sampled on posedge clk
//  clk_flash_anim  in   1            slow animation toggle; each level change = one tick
//  ch_start        in   NUM_CH       per-channel start/restart strobe (1 cycle)
//  ch_stop         in   NUM_CH       per-channel stop strobe (1 cycle)
//  ch_mode         in   2*NUM_CH     [2c+1:2c]: 00 loop, 01 ping-pong, 10 one-shot, 11 hold
//  ch_div          in   DIV_W*NUM_CH per-channel prescale value, latched at start
//  ch_busy         out  NUM_CH       1 while channel in RUN
//  ch_done         out  NUM_CH       1-cycle pulse when one-shot reaches last frame
//  id              out  ID_W*NUM_CH  [ID_W*(c+1)-1:ID_W*c] current sprite id of channel c
// BEHAVIOUR
//  Reset (rstn=1): all channels IDLE, id=NULL_ID, ch_busy=0, ch_done=0, frame=0, dir=up, pre=0;
//   prev_flash <= clk_flash_anim (no spurious tick on reset release).
//  Tick: tick = (clk_flash_anim != prev_flash); prev_flash updated every cycle; shared by all channels.
//  Per-channel FSM, states IDLE / RUN / STOP; all outputs registered (1-cycle latency from cause).
//  IDLE: id=NULL_ID. ch_start -> RUN, frame=0, dir=up, pre=0, latch mode and div.
//  RUN: id=BASE_ID+frame, ch_busy=1. On tick: pre==div_l -> pre=0 and advance; else pre=pre+1.
//  Advance, loop: frame==FRAMES-1 -> 0, else +1.
//  Advance, ping-pong up: at FRAMES-1 -> dir=down, frame=FRAMES-2. Down: at 0 -> dir=up, frame=1.
//  Advance, one-shot: frame<FRAMES-1 -> +1. Step from FRAMES-2 to FRAMES-1 -> STOP with ch_done=1 for one cycle.
//  Advance, hold: frame unchanged; prescaler still runs.
//  FRAMES==1: every mode holds frame 0. One-shot enters STOP on its first advance.
//  STOP: id=BASE_ID+FRAMES-1, ch_busy=0; ticks ignored.
//  ch_start in RUN or STOP: restart as from IDLE. It also clears a pending done; no done pulse that cycle.
//  ch_stop in RUN/STOP -> IDLE, id=NULL_ID next cycle.
//  ch_start and ch_stop together: start wins.
//  Start and tick in same cycle: start wins, and that tick is ignored for the channel.
//  Reset mid-animation: immediate return to reset values on next edge; no done pulse.
//  Arithmetic: frame width max(1,$clog2(FRAMES)); id=BASE_ID+frame truncated to ID_W.
//  Elaboration error if BASE_ID+FRAMES-1 > 2^ID_W-1.
//  Elaboration error if NULL_ID lies within [BASE_ID, BASE_ID+FRAMES-1].
//  ch_mode/ch_div changes during RUN have no effect until next start.
// TESTING
//  T1 reset: rstn=1 3 cycles while toggling flash -> all id=63, busy=0, done=0; release -> no advance until next toggle.
//  T2 loop, div=0, ch0: start, 5 toggles -> id 4,5,6,7,4,5; each step 1 cycle after toggle; busy=1.
//  T3 ping-pong, div=1, ch1: start, 12 toggles -> id 4,4,5,5,6,6,7,7,6,6,5,5,4 (advance every 2nd tick).
//  T4 one-shot, div=0, ch2: start, 3 toggles -> 4,5,6,7, done=1 one cycle, busy 1->0.
//  T4 cont.: more toggles hold id=7. Restart -> id=4, busy=1, no done.
//  T5 conflicts: start+stop same cycle -> RUN id=4; start coincident with toggle -> id=4, no advance.
//  T5 cont.: stop -> id=63 next cycle; other channels unaffected throughout.
//  T6 FRAMES=1, NUM_CH=1 build: loop and ping-pong stay id=BASE_ID. One-shot pulses done on first tick.

Source files
------------

// File: rtl/sprite_anim_seq_if.sv
// Control/status bundle between a sprite animation sequencer and its host.
// The host (master) issues per-channel start/stop strobes with mode and
// prescale settings; the sequencer (slave) reports busy/done and the
// current sprite id of every channel.
interface sprite_anim_seq_if #(
  parameter int NUM_CH = 4,
  parameter int ID_W   = 6,
  parameter int DIV_W  = 4
);
  logic [NUM_CH-1:0]       ch_start;
  logic [NUM_CH-1:0]       ch_stop;
  logic [2*NUM_CH-1:0]     ch_mode;
  logic [DIV_W*NUM_CH-1:0] ch_div;
  logic [NUM_CH-1:0]       ch_busy;
  logic [NUM_CH-1:0]       ch_done;
  logic [ID_W*NUM_CH-1:0]  id;

  modport master (
    output ch_start, ch_stop, ch_mode, ch_div,
    input  ch_busy, ch_done, id
  );

  modport slave (
    input  ch_start, ch_stop, ch_mode, ch_div,
    output ch_busy, ch_done, id
  );
endinterface

// File: rtl/sprite_anim_seq.sv
// Multi-channel sprite-frame sequencer. Each channel walks a sprite id
// through FRAMES consecutive ids starting at BASE_ID, paced by level changes
// of the shared clk_flash_anim toggle and a per-channel prescaler.
// Modes: loop, ping-pong, one-shot (done pulse on reaching the last frame)
// and hold. Idle channels present NULL_ID (transparent sprite).
// All outputs are registered: they reflect a cause one clock later.
module sprite_anim_seq #(
  parameter int NUM_CH  = 4,
  parameter int ID_W    = 6,
  parameter int FRAMES  = 4,
  parameter int BASE_ID = 4,
  parameter int NULL_ID = 63,
  parameter int DIV_W   = 4
) (
  input  logic                    clk,
  input  logic                    rstn,            // active-high synchronous reset
  input  logic                    clk_flash_anim,
  sprite_anim_seq_if.slave        bus
);

  // Frame counter needs at least one bit even for a single-frame animation.
  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam logic [FW-1:0]   LAST_F    = FW'(FRAMES - 1);
  localparam logic [ID_W-1:0] BASE_V    = ID_W'(BASE_ID);
  localparam logic [ID_W-1:0] LAST_ID_V = ID_W'(BASE_ID + FRAMES - 1);
  localparam logic [ID_W-1:0] NULL_V    = ID_W'(NULL_ID);

  localparam logic [1:0] MODE_LOOP = 2'b00;
  localparam logic [1:0] MODE_PING = 2'b01;
  localparam logic [1:0] MODE_ONE  = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  // Reject parameter sets whose ids cannot be represented or collide.
  generate
    if (FRAMES < 1) begin : g_err_frames
      $error("sprite_anim_seq: FRAMES must be at least 1");
    end
    if (BASE_ID + FRAMES - 1 > (2 ** ID_W) - 1) begin : g_err_range
      $error("sprite_anim_seq: last frame id does not fit in ID_W bits");
    end
    if ((NULL_ID >= BASE_ID) && (NULL_ID <= BASE_ID + FRAMES - 1)) begin : g_err_null
      $error("sprite_anim_seq: NULL_ID collides with an animation frame id");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  logic prev_flash_reg;
  logic tick;

  logic [NUM_CH-1:0]      busy_vec;
  logic [NUM_CH-1:0]      done_vec;
  logic [ID_W*NUM_CH-1:0] id_vec;

  // Track the flash toggle every cycle; during reset this captures the
  // current level so that reset release never produces a spurious tick.
  always_ff @(posedge clk) begin
    prev_flash_reg <= clk_flash_anim;
  end

  assign tick = (clk_flash_anim != prev_flash_reg);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t            state_reg, state_next;
      logic [FW-1:0]     frame_reg, frame_next;
      logic              dir_reg, dir_next;      // 0 = counting up, 1 = down
      logic [DIV_W-1:0]  pre_reg, pre_next;
      logic [1:0]        mode_reg, mode_next;
      logic [DIV_W-1:0]  div_reg, div_next;
      logic [ID_W-1:0]   id_reg, id_next;
      logic              busy_reg, busy_next;
      logic              done_reg, done_next;
      logic              start, stop;

      assign start = bus.ch_start[gi];
      assign stop  = bus.ch_stop[gi];

      // Channel state and registered outputs.
      always_ff @(posedge clk) begin
        if (rstn) begin
          state_reg <= ST_IDLE;
          frame_reg <= '0;
          dir_reg   <= 1'b0;
          pre_reg   <= '0;
          mode_reg  <= MODE_LOOP;
          div_reg   <= '0;
          id_reg    <= NULL_V;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end else begin
          state_reg <= state_next;
          frame_reg <= frame_next;
          dir_reg   <= dir_next;
          pre_reg   <= pre_next;
          mode_reg  <= mode_next;
          div_reg   <= div_next;
          id_reg    <= id_next;
          busy_reg  <= busy_next;
          done_reg  <= done_next;
        end
      end

      // Next-state: start beats stop and swallows a coincident tick; a
      // prescaled tick advances the frame according to the latched mode.
      always_comb begin
        state_next = state_reg;
        frame_next = frame_reg;
        dir_next   = dir_reg;
        pre_next   = pre_reg;
        mode_next  = mode_reg;
        div_next   = div_reg;
        done_next  = 1'b0;

        if (start) begin
          state_next = ST_RUN;
          frame_next = '0;
          dir_next   = 1'b0;
          pre_next   = '0;
          mode_next  = bus.ch_mode[2*gi +: 2];
          div_next   = bus.ch_div[DIV_W*gi +: DIV_W];
        end else begin
          case (state_reg)
            ST_RUN: begin
              if (stop) begin
                state_next = ST_IDLE;
              end else if (tick) begin
                if (pre_reg == div_reg) begin
                  pre_next = '0;
                  case (mode_reg)
                    MODE_LOOP: begin
                      frame_next = (frame_reg == LAST_F) ? '0 : frame_reg + FW'(1);
                    end
                    MODE_PING: begin
                      // A single frame has nowhere to bounce to.
                      if (FRAMES > 1) begin
                        if (!dir_reg) begin
                          if (frame_reg == LAST_F) begin
                            dir_next   = 1'b1;
                            frame_next = LAST_F - FW'(1);
                          end else begin
                            frame_next = frame_reg + FW'(1);
                          end
                        end else begin
                          if (frame_reg == '0) begin
                            dir_next   = 1'b0;
                            frame_next = FW'(1);
                          end else begin
                            frame_next = frame_reg - FW'(1);
                          end
                        end
                      end
                    end
                    MODE_ONE: begin
                      // Already on the last frame only when FRAMES==1.
                      if (frame_reg == LAST_F) begin
                        state_next = ST_STOP;
                        done_next  = 1'b1;
                      end else begin
                        frame_next = frame_reg + FW'(1);
                        if (frame_reg == LAST_F - FW'(1)) begin
                          state_next = ST_STOP;
                          done_next  = 1'b1;
                        end
                      end
                    end
                    MODE_HOLD: begin
                      frame_next = frame_reg;
                    end
                    default: begin
                      frame_next = frame_reg;
                    end
                  endcase
                end else begin
                  pre_next = pre_reg + DIV_W'(1);
                end
              end
            end
            ST_STOP: begin
              if (stop) begin
                state_next = ST_IDLE;
              end
            end
            default: begin
              state_next = state_reg;
            end
          endcase
        end

        case (state_next)
          ST_RUN:  id_next = BASE_V + ID_W'(frame_next);
          ST_STOP: id_next = LAST_ID_V;
          default: id_next = NULL_V;
        endcase
        busy_next = (state_next == ST_RUN);
      end

      assign busy_vec[gi]               = busy_reg;
      assign done_vec[gi]               = done_reg;
      assign id_vec[ID_W*gi +: ID_W]    = id_reg;
    end
  endgenerate

  assign bus.ch_busy = busy_vec;
  assign bus.ch_done = done_vec;
  assign bus.id      = id_vec;

endmodule

// File: tb/tb_sprite_anim_seq.sv
// Bench for sprite_anim_seq: a 4-channel/4-frame instance plus a
// 1-channel/1-frame instance share clk, reset and the flash toggle.
// Stimulus pushes hand-computed expected outputs into a scoreboard queue
// tagged with the cycle they must appear in; a monitor on the falling edge
// pops and compares them.
module tb_sprite_anim_seq;

  localparam int NUM_CH = 4;
  localparam int ID_W   = 6;
  localparam int DIV_W  = 4;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic flash = 1'b0;
  int   cyc_cnt = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // Cycle counter advances on every active edge.
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  sprite_anim_seq_if #(.NUM_CH(NUM_CH), .ID_W(ID_W), .DIV_W(DIV_W)) bus ();
  sprite_anim_seq_if #(.NUM_CH(1), .ID_W(ID_W), .DIV_W(DIV_W)) bus1 ();

  sprite_anim_seq #(
    .NUM_CH(NUM_CH), .ID_W(ID_W), .FRAMES(4), .BASE_ID(4), .NULL_ID(63), .DIV_W(DIV_W)
  ) dut (
    .clk(clk), .rstn(rstn), .clk_flash_anim(flash), .bus(bus)
  );

  sprite_anim_seq #(
    .NUM_CH(1), .ID_W(ID_W), .FRAMES(1), .BASE_ID(4), .NULL_ID(63), .DIV_W(DIV_W)
  ) dut1 (
    .clk(clk), .rstn(rstn), .clk_flash_anim(flash), .bus(bus1)
  );

  typedef struct {
    int          cyc;
    int          unit;   // 0 = four-channel instance, 1 = single-frame instance
    int          ch;
    logic [5:0]  id;
    logic        busy;
    logic        done;
    string       tag;
  } exp_t;

  exp_t sb_q[$];

  // Hand-maintained expected output levels.
  int   exp_id[NUM_CH];
  logic exp_busy[NUM_CH];
  int   e1_id;
  logic e1_busy;

  // Monitor: compare every expectation due in the current cycle.
  exp_t       m_e;
  logic [5:0] a_id;
  logic       a_busy, a_done;
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
      m_e = sb_q.pop_front();
      if (m_e.unit == 0) begin
        a_id   = bus.id[m_e.ch*ID_W +: ID_W];
        a_busy = bus.ch_busy[m_e.ch];
        a_done = bus.ch_done[m_e.ch];
      end else begin
        a_id   = bus1.id;
        a_busy = bus1.ch_busy[0];
        a_done = bus1.ch_done[0];
      end
      checks++;
      if (m_e.cyc != cyc_cnt || a_id !== m_e.id || a_busy !== m_e.busy || a_done !== m_e.done) begin
        failures++;
        $display("FAIL %s cyc=%0d unit%0d ch%0d: got id=%0d busy=%b done=%b, want id=%0d busy=%b done=%b",
                 m_e.tag, cyc_cnt, m_e.unit, m_e.ch, a_id, a_busy, a_done, m_e.id, m_e.busy, m_e.done);
      end
    end
  end

  // Apply strobes (and optionally a flash toggle) for one clock.
  task automatic drive(input logic [3:0] st, input logic [3:0] sp, input logic tog, input logic st1);
    bus.ch_start  = st;
    bus.ch_stop   = sp;
    bus1.ch_start = st1;
    if (tog) flash = ~flash;
    @(posedge clk);
    #1;
    bus.ch_start  = '0;
    bus.ch_stop   = '0;
    bus1.ch_start = 1'b0;
  endtask

  // Queue expectations for all channels of both instances this cycle.
  task automatic expect_now(input logic [3:0] done_m, input logic d1, input string tag);
    exp_t e;
    for (int c = 0; c < NUM_CH; c++) begin
      e.cyc = cyc_cnt; e.unit = 0; e.ch = c;
      e.id = 6'(exp_id[c]); e.busy = exp_busy[c]; e.done = done_m[c]; e.tag = tag;
      sb_q.push_back(e);
    end
    e.cyc = cyc_cnt; e.unit = 1; e.ch = 0;
    e.id = 6'(e1_id); e.busy = e1_busy; e.done = d1; e.tag = tag;
    sb_q.push_back(e);
    $display("cyc=%0d %s ids=%0d,%0d,%0d,%0d small=%0d", cyc_cnt, tag,
             exp_id[0], exp_id[1], exp_id[2], exp_id[3], e1_id);
  endtask

  int loop_seq[5] = '{5, 6, 7, 4, 5};
  int pp_seq[12]  = '{4, 5, 5, 6, 6, 7, 7, 6, 6, 5, 5, 4};

  initial begin
    for (int c = 0; c < NUM_CH; c++) begin
      exp_id[c] = 63; exp_busy[c] = 1'b0;
    end
    e1_id = 63; e1_busy = 1'b0;
    bus.ch_start = '0; bus.ch_stop = '0;
    bus.ch_mode = 8'b11_10_01_00;   // ch3 hold, ch2 one-shot, ch1 ping-pong, ch0 loop
    bus.ch_div  = 16'h0010;         // ch1 div=1, others 0
    bus1.ch_start = 1'b0; bus1.ch_stop = 1'b0;
    bus1.ch_mode = 2'b00; bus1.ch_div = '0;
    @(posedge clk);
    #1;

    // T1: reset held while the flash toggles
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, 4'b0000, 1'b1, 1'b0);
      expect_now(4'b0000, 1'b0, "t1_reset");
    end
    rstn = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    expect_now(4'b0000, 1'b0, "t1_release");

    // T2: ch0 loop div=0; ch3 started in hold as a bystander
    drive(4'b1001, 4'b0000, 1'b0, 1'b0);
    exp_id[0] = 4; exp_busy[0] = 1'b1; exp_id[3] = 4; exp_busy[3] = 1'b1;
    expect_now(4'b0000, 1'b0, "t2_start");
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    expect_now(4'b0000, 1'b0, "t2_no_tick");
    for (int i = 0; i < 5; i++) begin
      drive(4'b0000, 4'b0000, 1'b1, 1'b0);
      exp_id[0] = loop_seq[i];
      expect_now(4'b0000, 1'b0, "t2_loop");
    end

    // T3: stop ch0, ch1 ping-pong div=1; settings changed mid-run are ignored
    drive(4'b0010, 4'b0001, 1'b0, 1'b0);
    exp_id[0] = 63; exp_busy[0] = 1'b0; exp_id[1] = 4; exp_busy[1] = 1'b1;
    expect_now(4'b0000, 1'b0, "t3_start");
    bus.ch_div  = 16'h0000;
    bus.ch_mode = 8'b11_10_00_00;
    for (int i = 0; i < 12; i++) begin
      drive(4'b0000, 4'b0000, 1'b1, 1'b0);
      exp_id[1] = pp_seq[i];
      expect_now(4'b0000, 1'b0, "t3_pingpong");
    end

    // T4: stop ch1, ch2 one-shot div=0
    drive(4'b0100, 4'b0010, 1'b0, 1'b0);
    exp_id[1] = 63; exp_busy[1] = 1'b0; exp_id[2] = 4; exp_busy[2] = 1'b1;
    expect_now(4'b0000, 1'b0, "t4_start");
    drive(4'b0000, 4'b0000, 1'b1, 1'b0);
    exp_id[2] = 5;
    expect_now(4'b0000, 1'b0, "t4_step");
    drive(4'b0000, 4'b0000, 1'b1, 1'b0);
    exp_id[2] = 6;
    expect_now(4'b0000, 1'b0, "t4_step");
    drive(4'b0000, 4'b0000, 1'b1, 1'b0);
    exp_id[2] = 7; exp_busy[2] = 1'b0;
    expect_now(4'b0100, 1'b0, "t4_done");
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    expect_now(4'b0000, 1'b0, "t4_done_clear");
    for (int i = 0; i < 2; i++) begin
      drive(4'b0000, 4'b0000, 1'b1, 1'b0);
      expect_now(4'b0000, 1'b0, "t4_stop_hold");
    end
    drive(4'b0100, 4'b0000, 1'b0, 1'b0);
    exp_id[2] = 4; exp_busy[2] = 1'b1;
    expect_now(4'b0000, 1'b0, "t4_restart");
    for (int i = 0; i < 2; i++) begin
      drive(4'b0000, 4'b0000, 1'b1, 1'b0);
      exp_id[2] = 5 + i;
      expect_now(4'b0000, 1'b0, "t4_step2");
    end
    // restart on the tick that would have finished: no advance, no done
    drive(4'b0100, 4'b0000, 1'b1, 1'b0);
    exp_id[2] = 4;
    expect_now(4'b0000, 1'b0, "t4_restart_vs_done");

    // T5: conflicts
    drive(4'b0000, 4'b0100, 1'b0, 1'b0);
    exp_id[2] = 63; exp_busy[2] = 1'b0;
    expect_now(4'b0000, 1'b0, "t5_stop_ch2");
    drive(4'b0001, 4'b0001, 1'b0, 1'b0);
    exp_id[0] = 4; exp_busy[0] = 1'b1;
    expect_now(4'b0000, 1'b0, "t5_start_stop");
    drive(4'b0000, 4'b0000, 1'b1, 1'b0);
    exp_id[0] = 5;
    expect_now(4'b0000, 1'b0, "t5_advance");
    drive(4'b0001, 4'b0000, 1'b1, 1'b0);
    exp_id[0] = 4;
    expect_now(4'b0000, 1'b0, "t5_start_tick");
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    expect_now(4'b0000, 1'b0, "t5_no_tick");
    drive(4'b0000, 4'b0001, 1'b0, 1'b0);
    exp_id[0] = 63; exp_busy[0] = 1'b0;
    expect_now(4'b0000, 1'b0, "t5_stop");

    // Reset mid-animation (ch3 still running in hold)
    rstn = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    exp_id[3] = 63; exp_busy[3] = 1'b0;
    expect_now(4'b0000, 1'b0, "reset_mid");
    rstn = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    expect_now(4'b0000, 1'b0, "reset_mid_rel");

    // T6: single-frame instance
    bus1.ch_mode = 2'b00;
    drive(4'b0000, 4'b0000, 1'b0, 1'b1);
    e1_id = 4; e1_busy = 1'b1;
    expect_now(4'b0000, 1'b0, "t6_loop_start");
    drive(4'b0000, 4'b0000, 1'b1, 1'b0);
    expect_now(4'b0000, 1'b0, "t6_loop_tick");
    bus1.ch_mode = 2'b01;
    drive(4'b0000, 4'b0000, 1'b0, 1'b1);
    expect_now(4'b0000, 1'b0, "t6_pp_start");
    drive(4'b0000, 4'b0000, 1'b1, 1'b0);
    expect_now(4'b0000, 1'b0, "t6_pp_tick");
    bus1.ch_mode = 2'b10;
    drive(4'b0000, 4'b0000, 1'b0, 1'b1);
    expect_now(4'b0000, 1'b0, "t6_one_start");
    drive(4'b0000, 4'b0000, 1'b1, 1'b0);
    e1_busy = 1'b0;
    expect_now(4'b0000, 1'b1, "t6_one_done");
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    expect_now(4'b0000, 1'b0, "t6_one_after");

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(posedge clk);
    if (sb_q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
